rr_arbiter_hold: RTL and testbench
==================================

RR_ARBITER_HOLD -- requirements
Module: rr_arbiter_hold

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..32.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive cycles one tenure may keep the grant; legal range >=1.
REQ-003 Derived localparam IDXW = max(1, clog2(NREQ)): width of grant_id.
REQ-004 Derived localparam CNTW = max(1, clog2(MAX_HOLD)): width of the tenure counter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low; the block is in reset while rst=0.
REQ-007 req  input  NREQ  per-requester request level.
REQ-008 hold  input  NREQ  per-requester request to keep the current grant; only the owner's bit is used.
REQ-009 grant  output  NREQ  registered one-hot grant, or all zeros.
REQ-010 grant_valid  output  1  registered; equals |grant.
REQ-011 grant_id  output  IDXW  registered index of the granted requester; holds its last value while grant_valid=0.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE (no owner) and BUSY (owner o = grant_id, grant_valid=1).
REQ-013 Pointer ptr (IDXW bits) SHALL hold the index of the most recently granted requester.
REQ-014 Selection SHALL search req from index (ptr+1) mod NREQ upward, wrapping modulo NREQ, and pick the first set bit; the search SHALL include ptr itself last.
REQ-015 Latency: a request sampled at edge k SHALL appear on grant after edge k; no combinational path from req/hold to any output.
REQ-016 IDLE: if |req=0, stay IDLE, grant=0; otherwise load grant with the selected one-hot, set grant_id and ptr to the selected index, clear hold_cnt, go BUSY.
REQ-017 BUSY, keep: if req[o]=1 and hold[o]=1 and hold_cnt < MAX_HOLD-1, grant is unchanged and hold_cnt increments.
REQ-018 BUSY, release: otherwise re-arbitrate per REQ-014 using the current req; a new grant loads with no idle cycle, ptr=new index, hold_cnt=0.
REQ-019 BUSY, no requesters at release: grant=0, grant_valid=0, go IDLE; ptr and grant_id retained.
REQ-020 Forced rotation: when hold_cnt = MAX_HOLD-1, the tenure SHALL end even with hold[o]=1; if another requester is pending it wins per REQ-014.
REQ-021 If the owner is the only requester at release, it SHALL be re-granted as a new tenure (hold_cnt=0).
REQ-022 MAX_HOLD=1 SHALL make every tenure one cycle; hold has no effect.
REQ-023 hold bits of non-owners and hold without req SHALL be ignored.
REQ-024 grant SHALL never have more than one bit set; grant_valid SHALL always equal |grant.
REQ-025 hold_cnt SHALL saturate logically at MAX_HOLD-1 and never wrap.

Reset
REQ-026 While rst=0, immediately and asynchronously: grant=0, grant_valid=0, grant_id=0, hold_cnt=0, FSM=IDLE, ptr=NREQ-1, so requester 0 has first priority after release.
REQ-027 Reset asserted mid-tenure SHALL drop the grant without waiting for a clock edge; the first edge after release SHALL arbitrate per REQ-016.

Verification (NREQ=4, MAX_HOLD=4 unless stated)
REQ-028 Reset release, req=4'b1111, hold=0 held -> grant 0001,0010,0100,1000,0001 on successive edges; grant_valid=1 from the first edge.
REQ-029 req=4'b0100, hold=0 -> grant=0100 and grant_id=2 every cycle, with no gap.
REQ-030 req=4'b1111, hold=4'b0001 -> grant=0001 for exactly 4 cycles, then 0010 for 1 cycle, then 0100.
REQ-031 Owner 0 holding with hold[0]=1 drops req[0] at cycle 2 of its tenure, req=4'b1010 -> next edge grant=0010; hold_cnt restarts.
REQ-032 All req drop while BUSY -> next edge grant=0, grant_valid=0, grant_id unchanged; later req=4'b1001 with ptr=1 -> grant=1000.
REQ-033 NREQ=3, ptr=2, req=3'b011 -> grant=001 (wrap); rst pulsed low mid-tenure -> outputs 0 before the next edge, first grant after release goes to lowest-index requester.

Source files
------------

// File: rtl/rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_hold
// Purpose  : Round-robin arbiter with owner-requested hold and bounded tenure.
// Revision : 1.0
// ============================================================================

module rr_arbiter_hold #(
    parameter  int NREQ     = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] hold,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_id
);

    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);
    localparam logic [IDXW-1:0] PTR_RST   = IDXW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IDXW-1:0] grant_id_q, grant_id_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;

    logic            sel_found;
    logic [IDXW-1:0] sel_idx;
    logic [IDXW-1:0] cand;
    logic            keep;

    // Search starts just after the last winner and visits ptr itself last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDXW'((int'(ptr_q) + i) % NREQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        keep = (state_q == S_BUSY) && req[grant_id_q] && hold[grant_id_q]
               && (hold_cnt_q < HOLD_LAST);

        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;

        if (keep) begin
            hold_cnt_d = hold_cnt_q + CNTW'(1);
        end else if (sel_found) begin
            state_d    = S_BUSY;
            grant_d    = ONE_HOT0 << sel_idx;
            grant_id_d = sel_idx;
            ptr_d      = sel_idx;
            hold_cnt_d = '0;
        end else begin
            // Nobody is asking: go idle but remember who won last.
            state_d    = S_IDLE;
            grant_d    = '0;
            hold_cnt_d = '0;
        end

        grant_valid_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            ptr_q         <= PTR_RST;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_hold
// Purpose  : Scoreboard bench for rr_arbiter_hold against a tenure-level model.
// Revision : 1.0
// ============================================================================

module tb_rr_arbiter_hold;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] hold = '0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;

    logic       rst3 = 1'b0;
    logic [2:0] req3 = '0;
    logic [2:0] hold3 = '0;
    logic [2:0] grant3;
    logic       gv3;
    logic [1:0] gid3;

    always #5 clk = ~clk;

    rr_arbiter_hold #(.NREQ(N), .MAX_HOLD(MH)) u_dut (
        .clk(clk), .rst(rst), .req(req), .hold(hold),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    rr_arbiter_hold #(.NREQ(3), .MAX_HOLD(2)) u_dut3 (
        .clk(clk), .rst(rst3), .req(req3), .hold(hold3),
        .grant(grant3), .grant_valid(gv3), .grant_id(gid3)
    );

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Model state: who owns the grant, how many cycles it has had, last winner.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_id    = 0;
    int m_len   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_id    = 0;
        m_len   = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic [3:0] h);
        int c;
        if (m_owner >= 0 && r[2'(m_owner)] && h[2'(m_owner)] && m_len < MH) begin
            m_len++;
        end else begin
            m_owner = -1;
            for (int j = 1; j <= N; j++) begin
                c = (m_ptr + j) % N;
                if (m_owner < 0 && r[2'(c)]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_ptr = m_owner;
                m_id  = m_owner;
                m_len = 1;
            end
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.v  = (m_owner >= 0);
        e.id = 2'(m_id);
        return e;
    endfunction

    task automatic step(input logic [3:0] r, input logic [3:0] h);
        req  = r;
        hold = h;
        model_step(r, h);
        q.push_back(model_exp());
        @(posedge clk);
        #2;
    endtask

    // Directed step: the expected grant is a literal written from the requirements.
    task automatic step_exp(input logic [3:0] r, input logic [3:0] h, input logic [3:0] g,
                            input logic [1:0] id);
        exp_t e;
        req  = r;
        hold = h;
        model_step(r, h);
        e.g  = g;
        e.v  = |g;
        e.id = id;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL reset_queue_not_drained actual=%0d expected=0", q.size());
            q.delete();
        end
        rst = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'h0);
        chk("async_rst_valid", 32'(grant_valid), 32'h0);
        chk("async_rst_id", 32'(grant_id), 32'h0);
        model_reset();
        req  = '0;
        hold = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic step3(input string nm, input logic [2:0] r, input logic [2:0] h,
                         input logic [2:0] g, input logic [1:0] id);
        req3  = r;
        hold3 = h;
        @(posedge clk);
        #1;
        chk({nm, "_grant"}, 32'(grant3), 32'(g));
        chk({nm, "_id"}, 32'(gid3), 32'(id));
        chk({nm, "_valid"}, 32'(gv3), 32'(|g));
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            checks++;
            if (!$onehot0(grant) || grant_valid !== (|grant)) begin
                failures++;
                $display("FAIL grant_invariant grant=%b valid=%b", grant, grant_valid);
            end
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                checks++;
                if (grant !== mon_e.g || grant_valid !== mon_e.v || grant_id !== mon_e.id) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t actual grant=%b valid=%b id=%0d expected grant=%b valid=%b id=%0d",
                             $time, grant, grant_valid, grant_id, mon_e.g, mon_e.v, mon_e.id);
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        logic [3:0] h;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_valid", 32'(grant_valid), 32'h0);
        chk("reset_id", 32'(grant_id), 32'h0);
        model_reset();
        rst = 1'b1;

        // Rotation with everyone requesting, no hold.
        step_exp(4'hF, 4'h0, 4'b0001, 2'd0);
        step_exp(4'hF, 4'h0, 4'b0010, 2'd1);
        step_exp(4'hF, 4'h0, 4'b0100, 2'd2);
        step_exp(4'hF, 4'h0, 4'b1000, 2'd3);
        step_exp(4'hF, 4'h0, 4'b0001, 2'd0);

        // Lone requester is re-granted every cycle without a gap.
        step_exp(4'b0100, 4'h0, 4'b0100, 2'd2);
        step_exp(4'b0100, 4'h0, 4'b0100, 2'd2);
        step_exp(4'b0100, 4'h0, 4'b0100, 2'd2);

        // Hold capped at four cycles, then forced rotation.
        do_reset();
        for (int i = 0; i < 4; i++) step_exp(4'hF, 4'b0001, 4'b0001, 2'd0);
        step_exp(4'hF, 4'b0001, 4'b0010, 2'd1);
        step_exp(4'hF, 4'b0001, 4'b0100, 2'd2);

        // Owner drops its request mid-tenure.
        do_reset();
        step_exp(4'hF, 4'b0001, 4'b0001, 2'd0);
        step_exp(4'hF, 4'b0001, 4'b0001, 2'd0);
        step_exp(4'b1010, 4'b0001, 4'b0010, 2'd1);
        step_exp(4'b1010, 4'b0000, 4'b1000, 2'd3);

        // All requests drop while busy; later search resumes after ptr=1.
        do_reset();
        step_exp(4'b0010, 4'h0, 4'b0010, 2'd1);
        step_exp(4'b0000, 4'h0, 4'b0000, 2'd1);
        step_exp(4'b0000, 4'h0, 4'b0000, 2'd1);
        step_exp(4'b1001, 4'h0, 4'b1000, 2'd3);

        // Non-owner hold bits and hold without request are ignored.
        do_reset();
        step_exp(4'b0011, 4'b1110, 4'b0001, 2'd0);
        step_exp(4'b0011, 4'b1110, 4'b0010, 2'd1);
        step_exp(4'b0011, 4'b1110, 4'b0010, 2'd1);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            r = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
            h = 4'($urandom | $urandom);
            step(r, h);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'h0);

        // Three requesters, shorter hold limit.
        rst3 = 1'b1;
        step3("n3_first", 3'b100, 3'b000, 3'b100, 2'd2);
        step3("n3_wrap", 3'b011, 3'b000, 3'b001, 2'd0);
        step3("n3_keep", 3'b011, 3'b001, 3'b001, 2'd0);
        rst3 = 1'b0;
        #1;
        chk("n3_async_rst_grant", 32'(grant3), 32'h0);
        chk("n3_async_rst_valid", 32'(gv3), 32'h0);
        req3  = 3'b110;
        hold3 = 3'b000;
        @(posedge clk);
        #2;
        rst3 = 1'b1;
        step3("n3_after_rst", 3'b110, 3'b000, 3'b010, 2'd1);
        step3("n3_next", 3'b110, 3'b000, 3'b100, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
